tft_timing_controller: RTL and testbench

Scan-timing master and pixel output stage for the 480x272 TFT panel on the synthesis rig. It generates the `tft_x`/`tft_y`/`tft_new_frame` scan stream that the pixel source (`mips_debugger`) consumes. It captures that source's `color` after a fixed latency and drives the panel pins (pixel clock, DE, syncs, RGB). It also sequences panel DISP and backlight on and off.

---
 rtl/tft_pkg.sv | 30 +++
 rtl/tft_timing_controller_if.sv | 18 +
 rtl/tft_scan_counter.sv | 69 ++++++
 rtl/tft_timing_controller.sv | 165 ++++++++++++++++
 tb/tb_tft_timing_controller.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/tft_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : tft_pkg
//  Description : Shared state encoding and default timing for the 480x272 TFT.
//  Revision    : 1.0
// ============================================================================
package tft_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_PWRUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_PWRDN = 2'd3
    } tft_state_e;

    localparam int c_DEF_H_ACTIVE = 480;
    localparam int c_DEF_H_FRONT  = 2;
    localparam int c_DEF_H_SYNC   = 41;
    localparam int c_DEF_H_BACK   = 2;
    localparam int c_DEF_V_ACTIVE = 272;
    localparam int c_DEF_V_FRONT  = 2;
    localparam int c_DEF_V_SYNC   = 10;
    localparam int c_DEF_V_BACK   = 2;

    localparam int c_RGB_W = 24;
    localparam int c_X_W   = 10;
    localparam int c_Y_W   = 9;

endpackage
`default_nettype wire

// File: rtl/tft_timing_controller_if.sv
`default_nettype none
// ============================================================================
//  Interface   : tft_timing_controller_if
//  Description : Scan stream to the pixel source and its returned colour.
//  Revision    : 1.0
// ============================================================================
interface tft_timing_controller_if;
    import tft_pkg::*;

    logic [c_X_W-1:0]   tft_x;
    logic [c_Y_W-1:0]   tft_y;
    logic               tft_new_frame;
    logic [c_RGB_W-1:0] color_in;

    modport master (output tft_x, output tft_y, output tft_new_frame, input  color_in);
    modport slave  (input  tft_x, input  tft_y, input  tft_new_frame, output color_in);
endinterface
`default_nettype wire

// File: rtl/tft_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tft_scan_counter
//  Description : Pixel-clock divider and raw x/y scan counters.
//  Revision    : 1.0
// ============================================================================
module tft_scan_counter
    import tft_pkg::*;
#(
    parameter  int H_TOTAL   = 525,
    parameter  int V_TOTAL   = 286,
    parameter  int PIXEL_DIV = 4,
    localparam int c_DIV_W   = $clog2(PIXEL_DIV)
) (
    input  wire logic               clk,
    input  wire logic               rstb,
    input  wire logic               i_run,
    output logic [c_DIV_W-1:0]      o_div,
    output logic                    o_tick,
    output logic                    o_x_wrap,
    output logic                    o_y_wrap,
    output logic [c_X_W-1:0]        o_x,
    output logic [c_Y_W-1:0]        o_y,
    output logic                    o_pclk
);

    logic [c_DIV_W-1:0] r_div;
    logic [c_X_W-1:0]   r_x;
    logic [c_Y_W-1:0]   r_y;
    logic               r_pclk;
    logic [c_DIV_W-1:0] w_div_nxt;
    logic               w_tick;
    logic               w_x_wrap;
    logic               w_y_wrap;

    assign w_tick    = (r_div == c_DIV_W'(PIXEL_DIV - 1));
    assign w_div_nxt = w_tick ? '0 : r_div + 1'b1;
    assign w_x_wrap  = w_tick && (r_x == c_X_W'(H_TOTAL - 1));
    assign w_y_wrap  = w_x_wrap && (r_y == c_Y_W'(V_TOTAL - 1));

    // Pixel clock is registered from the next divider value so it lines up with r_div.
    always_ff @(posedge clk) begin
        if (!rstb || !i_run) begin
            r_div  <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_pclk <= 1'b0;
        end else begin
            r_div  <= w_div_nxt;
            r_pclk <= (w_div_nxt >= c_DIV_W'(PIXEL_DIV / 2));
            if (w_tick) begin
                r_x <= w_x_wrap ? '0 : r_x + 1'b1;
                if (w_x_wrap) begin
                    r_y <= w_y_wrap ? '0 : r_y + 1'b1;
                end
            end
        end
    end

    assign o_div    = r_div;
    assign o_tick   = w_tick;
    assign o_x_wrap = w_x_wrap;
    assign o_y_wrap = w_y_wrap;
    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_pclk   = r_pclk;

endmodule
`default_nettype wire

// File: rtl/tft_timing_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tft_timing_controller
//  Description : TFT scan master, latency-aligned pixel stage and power sequencer.
//  Revision    : 1.0
// ============================================================================
module tft_timing_controller
    import tft_pkg::*;
#(
    parameter int H_ACTIVE      = c_DEF_H_ACTIVE,
    parameter int H_FRONT       = c_DEF_H_FRONT,
    parameter int H_SYNC        = c_DEF_H_SYNC,
    parameter int H_BACK        = c_DEF_H_BACK,
    parameter int V_ACTIVE      = c_DEF_V_ACTIVE,
    parameter int V_FRONT       = c_DEF_V_FRONT,
    parameter int V_SYNC        = c_DEF_V_SYNC,
    parameter int V_BACK        = c_DEF_V_BACK,
    parameter int PIXEL_DIV     = 4,
    parameter int COLOR_LATENCY = 1,
    parameter int PWR_FRAMES    = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rstb,
    input  wire logic                   ena,
    tft_timing_controller_if.master     pix,
    output logic                        tft_clk,
    output logic                        tft_de,
    output logic                        tft_hsync_n,
    output logic                        tft_vsync_n,
    output logic [c_RGB_W-1:0]          tft_rgb,
    output logic                        tft_disp,
    output logic                        tft_backlight,
    output logic                        active
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_DIV_W   = $clog2(PIXEL_DIV);
    localparam int c_FR_W    = $clog2(PWR_FRAMES + 1);

    localparam logic [c_X_W-1:0]   c_X_ACT   = c_X_W'(H_ACTIVE);
    localparam logic [c_X_W-1:0]   c_HS_BEG  = c_X_W'(H_ACTIVE + H_FRONT);
    localparam logic [c_X_W-1:0]   c_HS_END  = c_X_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [c_Y_W-1:0]   c_Y_ACT   = c_Y_W'(V_ACTIVE);
    localparam logic [c_Y_W-1:0]   c_VS_BEG  = c_Y_W'(V_ACTIVE + V_FRONT);
    localparam logic [c_Y_W-1:0]   c_VS_END  = c_Y_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [c_Y_W-1:0]   c_NF_Y    = c_Y_W'(V_ACTIVE - 1);
    localparam logic [c_DIV_W-1:0] c_LOAD    = c_DIV_W'(COLOR_LATENCY - 1);
    localparam logic [c_FR_W-1:0]  c_FR_LAST = c_FR_W'(PWR_FRAMES - 1);

    tft_state_e          r_state, w_state_nxt;
    logic [c_FR_W-1:0]   r_frames, w_frames_nxt;

    logic [c_DIV_W-1:0]  w_div;
    logic                w_tick, w_x_wrap, w_y_wrap, w_pclk;
    logic [c_X_W-1:0]    w_x;
    logic [c_Y_W-1:0]    w_y;
    logic                w_in_active, w_show, w_hs, w_vs, w_load;

    logic                r_de, r_hs_n, r_vs_n, r_new_frame;
    logic [c_RGB_W-1:0]  r_rgb;

    tft_scan_counter #(
        .H_TOTAL   (c_H_TOTAL),
        .V_TOTAL   (c_V_TOTAL),
        .PIXEL_DIV (PIXEL_DIV)
    ) u_scan (
        .clk      (clk),
        .rstb     (rstb),
        .i_run    (r_state != ST_OFF),
        .o_div    (w_div),
        .o_tick   (w_tick),
        .o_x_wrap (w_x_wrap),
        .o_y_wrap (w_y_wrap),
        .o_x      (w_x),
        .o_y      (w_y),
        .o_pclk   (w_pclk)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state  <= ST_OFF;
            r_frames <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_frames <= w_frames_nxt;
        end
    end

    // State changes only on whole-frame boundaries so no frame is ever cut short.
    always_comb begin
        w_state_nxt  = r_state;
        w_frames_nxt = r_frames;
        case (r_state)
            ST_OFF: begin
                w_frames_nxt = '0;
                if (ena) w_state_nxt = ST_PWRUP;
            end
            ST_PWRUP: begin
                if (w_y_wrap) begin
                    if (r_frames == c_FR_LAST) begin
                        w_state_nxt  = ST_RUN;
                        w_frames_nxt = '0;
                    end else begin
                        w_frames_nxt = r_frames + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_y_wrap && !ena) w_state_nxt = ST_PWRDN;
            end
            ST_PWRDN: begin
                if (w_y_wrap) begin
                    if (r_frames == c_FR_LAST) begin
                        w_state_nxt  = ST_OFF;
                        w_frames_nxt = '0;
                    end else begin
                        w_frames_nxt = r_frames + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    assign w_in_active = (w_x < c_X_ACT) && (w_y < c_Y_ACT);
    assign w_show      = (r_state == ST_RUN) && w_in_active;
    assign w_hs        = (w_x >= c_HS_BEG) && (w_x < c_HS_END);
    assign w_vs        = (w_y >= c_VS_BEG) && (w_y < c_VS_END);
    // COLOR_LATENCY clocks after the x/y edge the source colour is valid; capture all pins together.
    assign w_load      = (w_div == c_LOAD);

    always_ff @(posedge clk) begin
        if (!rstb || r_state == ST_OFF) begin
            r_de        <= 1'b0;
            r_rgb       <= '0;
            r_hs_n      <= 1'b1;
            r_vs_n      <= 1'b1;
            r_new_frame <= 1'b0;
        end else begin
            if (w_load) begin
                r_de   <= w_show;
                r_rgb  <= w_show ? pix.color_in : '0;
                r_hs_n <= !w_hs;
                r_vs_n <= !w_vs;
            end
            r_new_frame <= w_x_wrap && (w_y == c_NF_Y);
        end
    end

    assign pix.tft_x         = w_x;
    assign pix.tft_y         = w_y;
    assign pix.tft_new_frame = r_new_frame;

    assign tft_clk       = w_pclk;
    assign tft_de        = r_de;
    assign tft_hsync_n   = r_hs_n;
    assign tft_vsync_n   = r_vs_n;
    assign tft_rgb       = r_rgb;
    assign tft_disp      = (r_state == ST_RUN);
    assign tft_backlight = (r_state == ST_RUN);
    assign active        = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_tft_timing_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tft_timing_controller
//  Description : Small-panel bench: checkpoint table plus pixel scoreboard.
//  Revision    : 1.0
// ============================================================================
module tb_tft_timing_controller;

    // Small panel: H_TOTAL=12, V_TOTAL=7, frame = 84 pixels = 336 clk.
    // k counts clk edges since the edge that leaves OFF; after edge k: div=k%4, pixel=k/4.
    localparam int K_RUN_END = 1008;   // y wrap that ends RUN after ena drops at k=768
    localparam int K_OFF     = 1344;   // end of the blank power-down frame
    localparam int NVEC      = 17;

    logic        clk = 1'b0;
    logic        rstb;
    logic        ena;
    logic        tft_clk, tft_de, tft_hsync_n, tft_vsync_n;
    logic [23:0] tft_rgb;
    logic        tft_disp, tft_backlight, active;

    int checks = 0;
    int errors = 0;
    int k      = -1;
    logic k_run = 1'b0;
    logic prev_tclk = 1'b0;
    int de_f1  = 0;
    int nf_cnt = 0;

    typedef struct packed {
        logic        de;
        logic [23:0] rgb;
        logic        hs_n;
        logic        vs_n;
    } px_t;
    px_t sbq[$];

    typedef struct {
        int         k;
        logic       ena;
        logic [9:0] x;
        logic [8:0] y;
        logic       tclk;
        logic       disp;
        logic       bl;
        logic       act;
    } vec_t;
    vec_t tbl[NVEC];

    tft_timing_controller_if pix_if ();

    tft_timing_controller #(
        .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .PIXEL_DIV(4), .COLOR_LATENCY(1), .PWR_FRAMES(1)
    ) dut (
        .clk           (clk),
        .rstb          (rstb),
        .ena           (ena),
        .pix           (pix_if),
        .tft_clk       (tft_clk),
        .tft_de        (tft_de),
        .tft_hsync_n   (tft_hsync_n),
        .tft_vsync_n   (tft_vsync_n),
        .tft_rgb       (tft_rgb),
        .tft_disp      (tft_disp),
        .tft_backlight (tft_backlight),
        .active        (active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (k_run) k <= k + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", name, got, exp, k);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_x"},         32'(pix_if.tft_x), 32'd0);
        chk({tag, "_y"},         32'(pix_if.tft_y), 32'd0);
        chk({tag, "_new_frame"}, 32'(pix_if.tft_new_frame), 32'd0);
        chk({tag, "_tft_clk"},   32'(tft_clk), 32'd0);
        chk({tag, "_de"},        32'(tft_de), 32'd0);
        chk({tag, "_hsync_n"},   32'(tft_hsync_n), 32'd1);
        chk({tag, "_vsync_n"},   32'(tft_vsync_n), 32'd1);
        chk({tag, "_rgb"},       32'(tft_rgb), 32'd0);
        chk({tag, "_disp"},      32'(tft_disp), 32'd0);
        chk({tag, "_backlight"}, 32'(tft_backlight), 32'd0);
        chk({tag, "_active"},    32'(active), 32'd0);
    endtask

    // Pixel source model: colour for the current x/y becomes valid one clk after x/y change.
    initial begin
        pix_if.color_in = '0;
        forever begin
            @(negedge clk);
            pix_if.color_in = 24'({pix_if.tft_y, pix_if.tft_x});
        end
    end

    // Scoreboard: expected pin values queued when a pixel starts, checked at the tft_clk rise.
    always @(negedge clk) begin : sb
        int         p;
        logic [9:0] mx;
        logic [8:0] my;
        logic       run, show, nf_exp;
        px_t        e;
        if (k >= 0 && k < K_OFF) begin
            p      = k / 4;
            mx     = 10'(p % 12);
            my     = 9'((p / 12) % 7);
            nf_exp = (k % 4 == 0) && (p % 84 == 48);
            chk("new_frame", 32'(pix_if.tft_new_frame), 32'(nf_exp));
            if (pix_if.tft_new_frame && k < 672) nf_cnt++;
            if (k % 4 == 0) begin
                run    = (k >= 336) && (k < K_RUN_END);
                show   = run && (mx < 10'd8) && (my < 9'd4);
                e.de   = show;
                e.rgb  = show ? 24'({my, mx}) : 24'd0;
                e.hs_n = !(mx == 10'd9 || mx == 10'd10);
                e.vs_n = !(my == 9'd5);
                sbq.push_back(e);
            end
            if (!prev_tclk && tft_clk) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("px_de",      32'(tft_de),      32'(e.de));
                    chk("px_rgb",     32'(tft_rgb),     32'(e.rgb));
                    chk("px_hsync_n", 32'(tft_hsync_n), 32'(e.hs_n));
                    chk("px_vsync_n", 32'(tft_vsync_n), 32'(e.vs_n));
                    if (tft_de && k >= 338 && k < 672) de_f1++;
                end
            end
        end
        prev_tclk = tft_clk;
    end

    initial begin
        //          k     ena   x      y     clk   disp  bl    act
        tbl[0]  = '{0,    1'b1, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2,    1'b1, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{4,    1'b1, 10'd1, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{47,   1'b1, 10'd11,9'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{48,   1'b1, 10'd0, 9'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{335,  1'b1, 10'd11,9'd6, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{336,  1'b1, 10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{530,  1'b1, 10'd0, 9'd4, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{671,  1'b1, 10'd11,9'd6, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{768,  1'b0, 10'd0, 9'd2, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1007, 1'b0, 10'd11,9'd6, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1008, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1100, 1'b1, 10'd11,9'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1343, 1'b1, 10'd11,9'd6, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1344, 1'b1, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1346, 1'b1, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1347, 1'b1, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0};

        rstb = 1'b0;
        ena  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rstb  = 1'b1;
        ena   = 1'b1;
        k_run = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            int guard;
            guard = 0;
            while (k < tbl[i].k && guard < 4000) begin
                @(negedge clk);
                guard++;
            end
            if (k != tbl[i].k) begin
                checks++;
                errors++;
                $display("FAIL vec%0d_reach: at k=%0d required k=%0d", i, k, tbl[i].k);
            end
            chk($sformatf("vec%0d_x", i),         32'(pix_if.tft_x),  32'(tbl[i].x));
            chk($sformatf("vec%0d_y", i),         32'(pix_if.tft_y),  32'(tbl[i].y));
            chk($sformatf("vec%0d_tft_clk", i),   32'(tft_clk),       32'(tbl[i].tclk));
            chk($sformatf("vec%0d_disp", i),      32'(tft_disp),      32'(tbl[i].disp));
            chk($sformatf("vec%0d_backlight", i), 32'(tft_backlight), 32'(tbl[i].bl));
            chk($sformatf("vec%0d_active", i),    32'(active),        32'(tbl[i].act));
            ena = tbl[i].ena;
        end

        chk("de_rises_frame1", 32'(de_f1), 32'd32);
        chk("new_frame_count", 32'(nf_cnt), 32'd2);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        // Re-powered from k=1345; RUN is reached at k=1681. Reset mid-RUN with ena held high.
        while (k < 1700) @(negedge clk);
        chk("run_before_reset", 32'(active), 32'd1);
        rstb = 1'b0;
        @(negedge clk);
        check_reset_vals("mid");
        rstb = 1'b1;
        repeat (3) @(negedge clk);
        chk("repwrup_tft_clk", 32'(tft_clk), 32'd1);
        chk("repwrup_de",      32'(tft_de),  32'd0);
        repeat (333) @(negedge clk);
        chk("repwrup_blank_active", 32'(active), 32'd0);
        @(negedge clk);
        chk("repwrup_run_active", 32'(active),   32'd1);
        chk("repwrup_run_disp",   32'(tft_disp), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, k=%0d", k);
        $fatal(1);
    end

endmodule
`default_nettype wire
